// File: rtl/ram_dp_arbiter.sv
// ram_dp_arbiter: shares one dual-port, byte-masked RAM between NUM_REQ requesters.
// Each cycle a round-robin scan from ptr grants up to two requests. The first
// valid requester drives RAM port A and the next one drives port B. Read data
// comes back on the cycle after the accept edge and is routed to the requester
// that issued the read.
//
// Ports
//   clock, reset            single clock; asynchronous active-high reset
//   req_valid/req_ready     per-requester handshake (ready is combinational)
//   req_wen/bwen/addr/wdata per-requester request payload, packed by index
//   rsp_valid/rsp_rdata     per-requester read response (1-cycle pulse)
//   ram_cen                 shared chip enable for the RAM macro
//   ram_*_a / ram_*_b       port A/B controls; ram_dout_* is registered read data

// Response path for one requester. It claims whichever port tag names this lane.
module ram_dp_arbiter_lane #(
  parameter int LANE = 0,
  parameter int IW   = 2,
  parameter int DW   = 32
) (
  input  logic          tag_a_vld_i,
  input  logic [IW-1:0] tag_a_idx_i,
  input  logic          tag_b_vld_i,
  input  logic [IW-1:0] tag_b_idx_i,
  input  logic [DW-1:0] dout_a_i,
  input  logic [DW-1:0] dout_b_i,
  output logic          rsp_valid_o,
  output logic [DW-1:0] rsp_rdata_o
);
  logic hit_a, hit_b;

  assign hit_a       = tag_a_vld_i && (tag_a_idx_i == IW'(LANE));
  assign hit_b       = tag_b_vld_i && (tag_b_idx_i == IW'(LANE));
  assign rsp_valid_o = hit_a | hit_b;
  // A requester wins at most one port per cycle, so both hits are never set together.
  assign rsp_rdata_o = hit_a ? dout_a_i : (hit_b ? dout_b_i : '0);
endmodule

module ram_dp_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 16,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int BWEN_WIDTH = DATA_WIDTH / 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_wen,
  input  logic [NUM_REQ*BWEN_WIDTH-1:0]    req_bwen,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [NUM_REQ*DATA_WIDTH-1:0]    rsp_rdata,
  output logic                             ram_cen,
  output logic                             ram_wen_a,
  output logic [BWEN_WIDTH-1:0]            ram_bwen_a,
  output logic [ADDR_WIDTH-1:0]            ram_addr_a,
  output logic [DATA_WIDTH-1:0]            ram_din_a,
  input  logic [DATA_WIDTH-1:0]            ram_dout_a,
  output logic                             ram_wen_b,
  output logic [BWEN_WIDTH-1:0]            ram_bwen_b,
  output logic [ADDR_WIDTH-1:0]            ram_addr_b,
  output logic [DATA_WIDTH-1:0]            ram_din_b,
  input  logic [DATA_WIDTH-1:0]            ram_dout_b
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic          vld;
    logic [IW-1:0] idx;
  } tag_t;

  // Indexed views of the flat request buses.
  logic [NUM_REQ-1:0][BWEN_WIDTH-1:0] bwen_v;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_v;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata_v;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] rdata_v;

  assign bwen_v    = req_bwen;
  assign addr_v    = req_addr;
  assign wdata_v   = req_wdata;
  assign rsp_rdata = rdata_v;

  logic [IW-1:0] ptr_q, ptr_d;
  tag_t          tag_a_q, tag_a_d, tag_b_q, tag_b_d;

  logic          a_found, b_found;
  logic [IW-1:0] a_idx, b_idx, last_idx;
  logic          coll, gnt_a, gnt_b;

  // Round-robin scan starting at ptr: the first two valid requesters win.
  always_comb begin
    int j;
    a_found = 1'b0;
    b_found = 1'b0;
    a_idx   = '0;
    b_idx   = '0;
    j       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req_valid[j]) begin
        if (!a_found) begin
          a_found = 1'b1;
          a_idx   = IW'(j);
        end else if (!b_found) begin
          b_found = 1'b1;
          b_idx   = IW'(j);
        end
      end
    end
  end

  // If the winners hit the same word and either one writes, drop B.
  // No later requester takes B's place this cycle.
  assign coll  = a_found && b_found && (addr_v[a_idx] == addr_v[b_idx]) &&
                 (req_wen[a_idx] || req_wen[b_idx]);
  assign gnt_a = a_found && !reset;
  assign gnt_b = b_found && !coll && !reset;

  always_comb begin
    req_ready = '0;
    if (gnt_a) req_ready[a_idx] = 1'b1;
    if (gnt_b) req_ready[b_idx] = 1'b1;
  end

  // RAM drive; an idle port is forced to all-zero controls.
  assign ram_cen    = gnt_a;  // a B grant always comes with an A grant
  assign ram_wen_a  = gnt_a && req_wen[a_idx];
  assign ram_bwen_a = gnt_a ? bwen_v[a_idx]  : '0;
  assign ram_addr_a = gnt_a ? addr_v[a_idx]  : '0;
  assign ram_din_a  = gnt_a ? wdata_v[a_idx] : '0;
  assign ram_wen_b  = gnt_b && req_wen[b_idx];
  assign ram_bwen_b = gnt_b ? bwen_v[b_idx]  : '0;
  assign ram_addr_b = gnt_b ? addr_v[b_idx]  : '0;
  assign ram_din_b  = gnt_b ? wdata_v[b_idx] : '0;

  // The pointer advances to one past the last requester that was granted.
  always_comb begin
    last_idx = gnt_b ? b_idx : a_idx;
    ptr_d    = ptr_q;
    if (gnt_a)
      ptr_d = (last_idx == IW'(NUM_REQ - 1)) ? '0 : last_idx + IW'(1);
  end

  // Tags make up the one-stage read pipeline: each records who owns the port's dout next cycle.
  assign tag_a_d = '{vld: gnt_a && !req_wen[a_idx], idx: a_idx};
  assign tag_b_d = '{vld: gnt_b && !req_wen[b_idx], idx: b_idx};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q   <= '0;
      tag_a_q <= '0;
      tag_b_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      tag_a_q <= tag_a_d;
      tag_b_q <= tag_b_d;
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    ram_dp_arbiter_lane #(
      .LANE (i),
      .IW   (IW),
      .DW   (DATA_WIDTH)
    ) u_lane (
      .tag_a_vld_i (tag_a_q.vld),
      .tag_a_idx_i (tag_a_q.idx),
      .tag_b_vld_i (tag_b_q.vld),
      .tag_b_idx_i (tag_b_q.idx),
      .dout_a_i    (ram_dout_a),
      .dout_b_i    (ram_dout_b),
      .rsp_valid_o (rsp_valid[i]),
      .rsp_rdata_o (rdata_v[i])
    );
  end
endmodule

// File: tb/tb_ram_dp_arbiter.sv
// Directed bench for ram_dp_arbiter with a behavioural dual-port byte-masked RAM.
module tb_ram_dp_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int BW = 4;

  logic              clock, reset;
  logic [NR-1:0]     req_valid, req_ready, req_wen, rsp_valid;
  logic [NR*BW-1:0]  req_bwen;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata, rsp_rdata;
  logic              ram_cen, ram_wen_a, ram_wen_b;
  logic [BW-1:0]     ram_bwen_a, ram_bwen_b;
  logic [AW-1:0]     ram_addr_a, ram_addr_b;
  logic [DW-1:0]     ram_din_a, ram_din_b, ram_dout_a, ram_dout_b;

  int vecs = 0;
  int errs = 0;
  int cnt [NR];

  ram_dp_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .DEPTH(16)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_bwen(req_bwen), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_cen(ram_cen),
    .ram_wen_a(ram_wen_a), .ram_bwen_a(ram_bwen_a), .ram_addr_a(ram_addr_a),
    .ram_din_a(ram_din_a), .ram_dout_a(ram_dout_a),
    .ram_wen_b(ram_wen_b), .ram_bwen_b(ram_bwen_b), .ram_addr_b(ram_addr_b),
    .ram_din_b(ram_din_b), .ram_dout_b(ram_dout_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM macro model: byte-masked writes, registered reads, dout held on writes.
  logic [DW-1:0] mem [16];
  always @(posedge clock) begin
    if (ram_cen) begin
      if (ram_wen_a) begin
        for (int k = 0; k < BW; k++)
          if (ram_bwen_a[k]) mem[ram_addr_a][k*8 +: 8] <= ram_din_a[k*8 +: 8];
      end else begin
        ram_dout_a <= mem[ram_addr_a];
      end
      if (ram_wen_b) begin
        for (int k = 0; k < BW; k++)
          if (ram_bwen_b[k]) mem[ram_addr_b][k*8 +: 8] <= ram_din_b[k*8 +: 8];
      end else begin
        ram_dout_b <= mem[ram_addr_b];
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    req_valid = '0; req_wen = '0; req_bwen = '0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic set_req(input int i, input logic w, input logic [BW-1:0] be,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = 1'b1;
    req_wen[i]            = w;
    req_bwen[i*BW +: BW]  = be;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  logic [AW-1:0] faddr [NR];
  logic [DW-1:0] fdata [NR];
  logic [NR-1:0] exp_v;

  initial begin
    faddr[0] = 4'd3; fdata[0] = 32'hDEADBEEF;
    faddr[1] = 4'd5; fdata[1] = 32'h11BB33DD;
    faddr[2] = 4'd9; fdata[2] = 32'h0A0B0C0D;
    faddr[3] = 4'd7; fdata[3] = 32'h77777777;
    for (int i = 0; i < NR; i++) cnt[i] = 0;

    reset = 1'b1; clr();
    repeat (2) @(negedge clock);
    set_req(0, 1'b0, 4'h0, 4'd3, 32'h0);
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_cen",   ram_cen,   0);
    chk("rst_rspv",  rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    @(negedge clock); reset = 1'b0; clr();

    // Write then read addr 3.
    @(negedge clock); clr(); set_req(0, 1'b1, 4'hF, 4'd3, 32'hDEADBEEF); #1;
    chk("wr_ready", req_ready, 4'b0001);
    chk("wr_wen_a", ram_wen_a, 1);
    chk("wr_addr_a", ram_addr_a, 3);
    chk("wr_din_a", ram_din_a, 32'hDEADBEEF);
    @(negedge clock); clr(); set_req(0, 1'b0, 4'hF, 4'd3, 32'h0); #1;
    chk("rd_ready", req_ready, 4'b0001);
    chk("rd_wen_a", ram_wen_a, 0);
    @(negedge clock); clr(); #1;
    chk("rd_rspv", rsp_valid, 4'b0001);
    chk("rd_data0", rsp_rdata[0*DW +: DW], 32'hDEADBEEF);

    // Byte mask.
    @(negedge clock); clr(); set_req(0, 1'b1, 4'hF, 4'd5, 32'h11223344); #1;
    chk("rsp_pulse", rsp_valid, 0);
    @(negedge clock); clr(); set_req(0, 1'b1, 4'h5, 4'd5, 32'hAABBCCDD); #1;
    chk("bm_bwen_a", ram_bwen_a, 4'h5);
    @(negedge clock); clr(); set_req(0, 1'b0, 4'h0, 4'd5, 32'h0);
    // Dual write req1/req2 (ptr=1) to preload addr 4 and 7.
    @(negedge clock); clr();
    set_req(1, 1'b1, 4'hF, 4'd4, 32'h44444444);
    set_req(2, 1'b1, 4'hF, 4'd7, 32'h77777777); #1;
    chk("bm_rspv", rsp_valid, 4'b0001);
    chk("bm_data0", rsp_rdata[0*DW +: DW], 32'h11BB33DD);
    chk("dw_ready", req_ready, 4'b0110);
    chk("dw_addr_b", ram_addr_b, 7);
    chk("dw_wen_b", ram_wen_b, 1);
    // ptr=3: lone req3 wraps ptr to 0.
    @(negedge clock); clr(); set_req(3, 1'b0, 4'h0, 4'd3, 32'h0); #1;
    chk("wrap_ready", req_ready, 4'b1000);
    chk("wrap_rspv", rsp_valid, 0);
    // Dual grant from ptr=0.
    @(negedge clock); clr();
    set_req(1, 1'b0, 4'h0, 4'd4, 32'h0);
    set_req(2, 1'b0, 4'h0, 4'd7, 32'h0); #1;
    chk("wrap_rspv3", rsp_valid, 4'b1000);
    chk("wrap_data3", rsp_rdata[3*DW +: DW], 32'hDEADBEEF);
    chk("dg_ready", req_ready, 4'b0110);
    chk("dg_addr_a", ram_addr_a, 4);
    chk("dg_addr_b", ram_addr_b, 7);
    // ptr must now be 3: req3 takes port A ahead of req0.
    @(negedge clock); clr();
    set_req(0, 1'b0, 4'h0, 4'd4, 32'h0);
    set_req(3, 1'b0, 4'h0, 4'd7, 32'h0); #1;
    chk("dg_rspv", rsp_valid, 4'b0110);
    chk("dg_data1", rsp_rdata[1*DW +: DW], 32'h44444444);
    chk("dg_data2", rsp_rdata[2*DW +: DW], 32'h77777777);
    chk("p3_ready", req_ready, 4'b1001);
    chk("p3_addr_a", ram_addr_a, 7);
    chk("p3_addr_b", ram_addr_b, 4);
    // ptr=1: lone req3 write moves ptr to 0.
    @(negedge clock); clr(); set_req(3, 1'b1, 4'hF, 4'd9, 32'h99990000); #1;
    chk("p3_rspv", rsp_valid, 4'b1001);
    chk("p3_data0", rsp_rdata[0*DW +: DW], 32'h44444444);
    chk("p3_data3", rsp_rdata[3*DW +: DW], 32'h77777777);
    chk("p3w_ready", req_ready, 4'b1000);

    // Collision: req0 writes addr 9 and req1 reads addr 9.
    @(negedge clock); clr();
    set_req(0, 1'b1, 4'hF, 4'd9, 32'h0A0B0C0D);
    set_req(1, 1'b0, 4'h0, 4'd9, 32'h0); #1;
    chk("col_ready", req_ready, 4'b0001);
    chk("col_cen", ram_cen, 1);
    chk("col_wen_b", ram_wen_b, 0);
    chk("col_bwen_b", ram_bwen_b, 0);
    chk("col_addr_b", ram_addr_b, 0);
    @(negedge clock); clr(); set_req(1, 1'b0, 4'h0, 4'd9, 32'h0); #1;
    chk("col2_ready", req_ready, 4'b0010);
    chk("col2_rspv", rsp_valid, 0);
    // ptr=2: lone req3 read moves ptr to 0 ahead of the fairness run.
    @(negedge clock); clr(); set_req(3, 1'b0, 4'h0, 4'd3, 32'h0); #1;
    chk("col_rspv", rsp_valid, 4'b0010);
    chk("col_data1", rsp_rdata[1*DW +: DW], 32'h0A0B0C0D);
    chk("pre_ready", req_ready, 4'b1000);

    // Fairness: all four requesters hold reads for 8 cycles.
    for (int c = 0; c <= 8; c++) begin
      @(negedge clock); clr();
      if (c < 8)
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 4'h0, faddr[i], 32'h0);
      #1;
      if (c < 8) chk($sformatf("fair_ready%0d", c), req_ready, (c % 2 == 0) ? 4'b0011 : 4'b1100);
      if (c == 0) begin
        chk("fair_rspv0", rsp_valid, 4'b1000);
        chk("fair_data3", rsp_rdata[3*DW +: DW], 32'hDEADBEEF);
      end else begin
        exp_v = (c % 2 == 1) ? 4'b0011 : 4'b1100;
        chk($sformatf("fair_rspv%0d", c), rsp_valid, exp_v);
        for (int i = 0; i < NR; i++) begin
          if (exp_v[i]) chk($sformatf("fair_data%0d_%0d", c, i), rsp_rdata[i*DW +: DW], fdata[i]);
          if (rsp_valid[i]) cnt[i]++;
        end
      end
    end
    for (int i = 0; i < NR; i++) chk($sformatf("fair_cnt%0d", i), cnt[i], 4);

    // Async reset while a response is showing and another read is pending.
    @(negedge clock); clr(); set_req(1, 1'b0, 4'h0, 4'd5, 32'h0); #1;
    chk("ar_ready", req_ready, 4'b0010);
    @(negedge clock); #1;
    chk("ar_rspv", rsp_valid, 4'b0010);
    chk("ar_data1", rsp_rdata[1*DW +: DW], 32'h11BB33DD);
    #2 reset = 1'b1; #1;
    chk("ar_rspv_now", rsp_valid, 0);
    chk("ar_rdata_now", rsp_rdata, 0);
    chk("ar_ready_now", req_ready, 0);
    chk("ar_cen_now", ram_cen, 0);
    @(negedge clock); #1;
    chk("ar_rspv_hold", rsp_valid, 0);
    reset = 1'b0; clr();
    @(negedge clock); #1;
    chk("ar_rspv_rel", rsp_valid, 0);
    // ptr=0 after reset: req0 on port A, req2 on port B.
    @(negedge clock); clr();
    set_req(0, 1'b0, 4'h0, 4'd3, 32'h0);
    set_req(2, 1'b0, 4'h0, 4'd9, 32'h0); #1;
    chk("ar_rspv_rel2", rsp_valid, 0);
    chk("ar_p_ready", req_ready, 4'b0101);
    chk("ar_p_addr_a", ram_addr_a, 3);
    chk("ar_p_addr_b", ram_addr_b, 9);
    @(negedge clock); clr(); #1;
    chk("ar_p_rspv", rsp_valid, 4'b0101);
    chk("ar_p_data0", rsp_rdata[0*DW +: DW], 32'hDEADBEEF);
    chk("ar_p_data2", rsp_rdata[2*DW +: DW], 32'h0A0B0C0D);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
